// File: rtl/hamming11_7_decoder.sv
// Streaming (11,7) Hamming decoder with a two-stage valid/ready pipeline.
// Stage 1 captures the codeword and its syndrome; stage 2 captures the corrected
// data, syndrome and error flags. Two saturating counters track error statistics.
module hamming11_7_decoder #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [10:0]      cw_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [6:0]       data_out,
  output logic [3:0]       syndrome_out,
  output logic             err_corrected,
  output logic             err_uncorrectable,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] corr_cnt,
  output logic [CNT_W-1:0] uncorr_cnt
);

  localparam logic [CNT_W-1:0] CntMax = '1;

  // Stage 1 state
  logic        r_s1_valid;
  logic [10:0] r_s1_cw;
  logic [3:0]  r_s1_syn;

  // Stage 2 state (drives the outputs directly)
  logic        r_s2_valid;
  logic [6:0]  r_s2_data;
  logic [3:0]  r_s2_syn;
  logic        r_s2_corr;
  logic        r_s2_uncorr;

  // Error-statistics counters
  logic [CNT_W-1:0] r_corr_cnt;
  logic [CNT_W-1:0] r_uncorr_cnt;

  // Combinational helpers
  logic             w_s1_adv;
  logic             w_s2_adv;
  logic             w_in_xfer;
  logic             w_out_xfer;
  logic [3:0]       w_syn;
  logic [10:0]      w_flip;
  logic [10:0]      w_fixed;
  logic [6:0]       w_data;
  logic             w_corr;
  logic             w_uncorr;
  logic [CNT_W-1:0] w_corr_cnt_nxt;
  logic [CNT_W-1:0] w_uncorr_cnt_nxt;

  // Pipeline advance and handshake; in_ready is combinational from out_ready.
  always_comb begin
    w_s2_adv   = !r_s2_valid || out_ready;
    w_s1_adv   = !r_s1_valid || w_s2_adv;
    w_in_xfer  = in_valid && w_s1_adv;
    w_out_xfer = r_s2_valid && out_ready;
  end

  assign in_ready = w_s1_adv;

  // Syndrome of the incoming word; cw_in[k-1] holds position k.
  always_comb begin
    w_syn[0] = cw_in[0] ^ cw_in[2] ^ cw_in[4] ^ cw_in[6] ^ cw_in[8] ^ cw_in[10];
    w_syn[1] = cw_in[1] ^ cw_in[2] ^ cw_in[5] ^ cw_in[6] ^ cw_in[9] ^ cw_in[10];
    w_syn[2] = cw_in[3] ^ cw_in[4] ^ cw_in[5] ^ cw_in[6];
    w_syn[3] = cw_in[7] ^ cw_in[8] ^ cw_in[9] ^ cw_in[10];
  end

  // Stage 1 register; cw_in is only sampled on a real transfer so X is never captured.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s1_cw    <= '0;
      r_s1_syn   <= '0;
    end else if (w_s1_adv) begin
      r_s1_valid <= in_valid;
      if (in_valid) begin
        r_s1_cw  <= cw_in;
        r_s1_syn <= w_syn;
      end
    end
  end

  // Build the correction mask from the stage 1 syndrome.
  always_comb begin
    w_flip   = '0;
    w_corr   = 1'b0;
    w_uncorr = 1'b0;
    if (r_s1_syn >= 4'd12) begin
      // Syndromes 12..15 point outside the codeword: flag, do not touch data.
      w_uncorr = 1'b1;
    end else if (r_s1_syn != 4'd0) begin
      w_corr = 1'b1;
      for (int k = 1; k <= 11; k++) begin
        if (r_s1_syn == 4'(k)) begin
          w_flip[k-1] = 1'b1;
        end
      end
    end
  end

  // Apply the mask and extract the data positions {11,10,9,7,6,5,3}.
  always_comb begin
    w_fixed = r_s1_cw ^ w_flip;
    w_data  = {w_fixed[10], w_fixed[9], w_fixed[8], w_fixed[6],
               w_fixed[5], w_fixed[4], w_fixed[2]};
  end

  // Stage 2 register; fields only change when the stage is allowed to advance.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s2_valid  <= 1'b0;
      r_s2_data   <= '0;
      r_s2_syn    <= '0;
      r_s2_corr   <= 1'b0;
      r_s2_uncorr <= 1'b0;
    end else if (w_s2_adv) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_s2_data   <= w_data;
        r_s2_syn    <= r_s1_syn;
        r_s2_corr   <= w_corr;
        r_s2_uncorr <= w_uncorr;
      end
    end
  end

  // Counter next state: clear wins over increment, increments saturate.
  always_comb begin
    w_corr_cnt_nxt   = r_corr_cnt;
    w_uncorr_cnt_nxt = r_uncorr_cnt;
    if (cnt_clr) begin
      w_corr_cnt_nxt   = '0;
      w_uncorr_cnt_nxt = '0;
    end else if (w_out_xfer) begin
      if (r_s2_corr && (r_corr_cnt != CntMax)) begin
        w_corr_cnt_nxt = r_corr_cnt + 1'b1;
      end
      if (r_s2_uncorr && (r_uncorr_cnt != CntMax)) begin
        w_uncorr_cnt_nxt = r_uncorr_cnt + 1'b1;
      end
    end
  end

  // Counter registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_corr_cnt   <= '0;
      r_uncorr_cnt <= '0;
    end else begin
      r_corr_cnt   <= w_corr_cnt_nxt;
      r_uncorr_cnt <= w_uncorr_cnt_nxt;
    end
  end

  assign out_valid         = r_s2_valid;
  assign data_out          = r_s2_data;
  assign syndrome_out      = r_s2_syn;
  assign err_corrected     = r_s2_corr;
  assign err_uncorrectable = r_s2_uncorr;
  assign corr_cnt          = r_corr_cnt;
  assign uncorr_cnt        = r_uncorr_cnt;

  // w_in_xfer is kept for readability of the handshake; tie it off here.
  logic w_unused;
  assign w_unused = w_in_xfer;

endmodule
